// File: rtl/radio_timing_sequencer_if.sv
// radio_timing_sequencer_if: request/status bundle between a radio controller
// (master) and the radio timing sequencer (slave).
interface radio_timing_sequencer_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 radioEnableUnsynced;
   logic                 radioRxEnUnsynced;
   logic                 pllSettled;
   logic [CNT_WIDTH-1:0] tArstFs;
   logic                 radioEnableSynced;
   logic                 radioRxEnSynced;
   logic                 pllEnable;
   logic                 radioEnable;
   logic                 radioRxEn;
   logic                 busy;
   logic                 pllError;

   modport master (
      output radioEnableUnsynced, radioRxEnUnsynced, pllSettled, tArstFs,
      input  radioEnableSynced, radioRxEnSynced, pllEnable, radioEnable,
             radioRxEn, busy, pllError
   );

   modport slave (
      input  radioEnableUnsynced, radioRxEnUnsynced, pllSettled, tArstFs,
      output radioEnableSynced, radioRxEnSynced, pllEnable, radioEnable,
             radioRxEn, busy, pllError
   );
endinterface

// File: rtl/radio_timing_sequencer.sv
// radio_timing_sequencer: brings up the PLL, waits for lock plus a programmable
// settle time, then enables the radio datapath in the requested RX/TX mode.
// Optional feature: define RTS_PLL_TIMEOUT_EN to bound the PLL lock wait and
// report pllError; without it the lock wait is unbounded and pllError is 0.
module radio_timing_sequencer #(
   parameter int CNT_WIDTH   = 8,
   parameter int PLL_TIMEOUT = 255
) (
   input logic                     clk,
   input logic                     reset,
   radio_timing_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLL_WAIT  = 3'd1,
      ARST_WAIT = 3'd2,
      ACTIVE    = 3'd3,
      ERROR     = 3'd4
   } state_t;

   state_t               state;
   state_t               stateNext;
   logic                 enSync1;
   logic                 enSync2;
   logic                 rxSync1;
   logic                 rxSync2;
   logic [CNT_WIDTH-1:0] settleCnt;
   logic                 rxMode;
   logic                 pllEnableDec;
   logic                 radioEnableDec;
   logic                 radioRxEnDec;

   // Two-flop synchronizers for the enable and mode requests from the async domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enSync1 <= 1'b0;
         enSync2 <= 1'b0;
         rxSync1 <= 1'b0;
         rxSync2 <= 1'b0;
      end else begin
         enSync1 <= bus.radioEnableUnsynced;
         enSync2 <= enSync1;
         rxSync1 <= bus.radioRxEnUnsynced;
         rxSync2 <= rxSync1;
      end
   end

   assign bus.radioEnableSynced = enSync2;
   assign bus.radioRxEnSynced   = rxSync2;

`ifdef RTS_PLL_TIMEOUT_EN
   localparam int TO_W = $clog2(PLL_TIMEOUT + 1);

   logic [TO_W-1:0] pllWaitCnt;
   logic            pllTimeoutHit;

   assign pllTimeoutHit = (pllWaitCnt == TO_W'(PLL_TIMEOUT - 1));

   // PLL_WAIT cycle counter; any other state clears it so each entry starts from zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pllWaitCnt <= '0;
      end else if (state != PLL_WAIT) begin
         pllWaitCnt <= '0;
      end else if (!pllTimeoutHit) begin
         pllWaitCnt <= pllWaitCnt + TO_W'(1);
      end
   end
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; a dropped enable request overrides every other transition
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (enSync2) stateNext = PLL_WAIT;
         end
         PLL_WAIT: begin
            if (!enSync2) begin
               stateNext = IDLE;
            end else if (bus.pllSettled) begin
               stateNext = (bus.tArstFs == '0) ? ACTIVE : ARST_WAIT;
            end
`ifdef RTS_PLL_TIMEOUT_EN
            else if (pllTimeoutHit) begin
               stateNext = ERROR;
            end
`endif
         end
         ARST_WAIT: begin
            if (!enSync2) begin
               stateNext = IDLE;
            end else if (!bus.pllSettled) begin
               stateNext = PLL_WAIT;
            end else if (settleCnt <= CNT_WIDTH'(1)) begin
               stateNext = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!enSync2) begin
               stateNext = IDLE;
            end else if (!bus.pllSettled) begin
               stateNext = PLL_WAIT;
            end
         end
         ERROR: begin
            if (!enSync2) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Settle counter: loaded on every lock, counts down in ARST_WAIT, stops at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settleCnt <= '0;
      end else if (state == PLL_WAIT && bus.pllSettled) begin
         settleCnt <= bus.tArstFs;
      end else if (state == ARST_WAIT && settleCnt != '0) begin
         settleCnt <= settleCnt - CNT_WIDTH'(1);
      end
   end

   // Mode register: captures RX/TX only when leaving IDLE, later changes are ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxMode <= 1'b0;
      end else if (state == IDLE && enSync2) begin
         rxMode <= rxSync2;
      end
   end

   // Output decode from registered state only, so reset clears outputs immediately
   always_comb begin
      pllEnableDec   = 1'b0;
      radioEnableDec = 1'b0;
      radioRxEnDec   = 1'b0;
      case (state)
         PLL_WAIT, ARST_WAIT: begin
            pllEnableDec = 1'b1;
         end
         ACTIVE: begin
            pllEnableDec   = 1'b1;
            radioEnableDec = 1'b1;
            radioRxEnDec   = rxMode;
         end
         default: begin
            pllEnableDec = 1'b0;
         end
      endcase
   end

   assign bus.pllEnable   = pllEnableDec;
   assign bus.radioEnable = radioEnableDec;
   assign bus.radioRxEn   = radioRxEnDec;
   assign bus.busy        = (state != IDLE);

`ifdef RTS_PLL_TIMEOUT_EN
   assign bus.pllError = (state == ERROR);
`else
   assign bus.pllError = 1'b0;
`endif

endmodule
